// File: rtl/cop_dispatch.sv
// Coprocessor dispatch initiator: issues a held-operand request, freezes IF/ID, emits a writeback.
// Optional busy timeout with sticky error is compiled in with COP_DISPATCH_TIMEOUT_EN.
module cop_dispatch #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_is_cop,
    input  logic        flush,
    input  logic [31:0] id_operand,
    input  logic [4:0]  id_dest,
    output logic        cop_req,
    output logic [31:0] cop_data,
    input  logic        cop_ready,
    input  logic [31:0] cop_result,
    output logic        freeze,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_e;

    state_e      state_q;
    logic        cop_req_q;
    logic [31:0] cop_data_q;
    logic [4:0]  dest_q;
    logic        wb_en_q;
    logic [4:0]  wb_dest_q;
    logic [31:0] wb_data_q;
    logic        issue;

`ifdef COP_DISPATCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             expired;

    assign expired     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_err = err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^{TIMEOUT[0], CNT_W[0]};
    assign timeout_err = 1'b0;
`endif

    assign issue  = id_valid & id_is_cop & ~flush;
    // Hold the instruction in ID for its issue cycle and the whole wait.
    assign freeze = (state_q == BUSY) | issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cop_req_q  <= 1'b0;
            cop_data_q <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
`ifdef COP_DISPATCH_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                BUSY: begin
                    if (cop_ready) begin
                        state_q   <= WB;
                        cop_req_q <= 1'b0;
                        wb_en_q   <= 1'b1;
                        wb_dest_q <= dest_q;
                        wb_data_q <= cop_result;
`ifdef COP_DISPATCH_TIMEOUT_EN
                        cnt_q     <= '0;
                    end else if (expired) begin
                        state_q   <= IDLE;
                        cop_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    wb_en_q <= 1'b0;
                    if (issue) begin
                        state_q    <= BUSY;
                        cop_req_q  <= 1'b1;
                        cop_data_q <= id_operand;
                        dest_q     <= id_dest;
`ifdef COP_DISPATCH_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                    end else begin
                        state_q   <= IDLE;
                        cop_req_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cop_req  = cop_req_q;
    assign cop_data = cop_data_q;
    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_cop_dispatch.sv
// Scoreboard bench for cop_dispatch: directed ops push expected writebacks,
// a negedge monitor pops and compares every wb_en.
module tb_cop_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_is_cop;
    logic        flush;
    logic [31:0] id_operand;
    logic [4:0]  id_dest;
    logic        cop_req;
    logic [31:0] cop_data;
    logic        cop_ready;
    logic [31:0] cop_result;
    logic        freeze;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;
    logic [36:0] sb[$];
    logic prev_wb = 1'b0;

    cop_dispatch #(.TIMEOUT(48), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_is_cop(id_is_cop), .flush(flush),
        .id_operand(id_operand), .id_dest(id_dest),
        .cop_req(cop_req), .cop_data(cop_data),
        .cop_ready(cop_ready), .cop_result(cop_result),
        .freeze(freeze), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_data(wb_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            check("wb_not_consecutive", 64'(prev_wb), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_wb", 64'd1, 64'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check("wb_dest", 64'(wb_dest), 64'(e[36:32]));
                check("wb_data", 64'(wb_data), 64'(e[31:0]));
            end
        end
        prev_wb = wb_en;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_is_cop  = 1'b0;
        flush      = 1'b0;
        id_operand = '0;
        id_dest    = '0;
        cop_ready  = 1'b0;
        cop_result = '0;
    endtask

    // Issue in cycle 0, ready in BUSY cycle k, observe through k+3.
    task automatic run_op(input logic [31:0] opd, input logic [4:0] dst,
                          input int k, input logic [31:0] res);
        int frz, req, bad, wbs, wbat;
        frz = 0; req = 0; bad = 0; wbs = 0; wbat = -1;
        sb.push_back({dst, res});
        id_valid   = 1'b1;
        id_is_cop  = 1'b1;
        id_operand = opd;
        id_dest    = dst;
        for (int c = 0; c <= k + 3; c++) begin
            cop_ready  = (c == k);
            cop_result = (c == k) ? res : 32'hDEAD_BEEF;
            if (c == k + 1) begin
                id_valid  = 1'b0;
                id_is_cop = 1'b0;
            end
            @(negedge clk);
            if (freeze) frz++;
            if (cop_req) begin
                req++;
                if (cop_data !== opd) bad++;
            end
            if (wb_en) begin
                wbs++;
                wbat = c;
            end
            next();
        end
        idle_inputs();
        check("freeze_len", 64'(frz), 64'(k + 1));
        check("req_len", 64'(req), 64'(k));
        check("cop_data_stable", 64'(bad), 64'd0);
        check("wb_count", 64'(wbs), 64'd1);
        check("wb_cycle", 64'(wbat), 64'(k + 1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbs, req, lows, first, last;
        idle_inputs();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;

        @(negedge clk);
        check("reset_outs", {cop_req, cop_data, wb_en, wb_dest, wb_data,
                             timeout_err}, 64'd0);
        check("reset_freeze", 64'(freeze), 64'd0);
        next();

        // Basic operation
        run_op(32'h0000_0010, 5'd7, 35, 32'h3F80_0000);
        // Immediate ready
        run_op(32'h1234_5678, 5'd12, 1, 32'hCAFE_F00D);

`ifdef COP_DISPATCH_TIMEOUT_EN
        // Timeout: 48 BUSY cycles, sticky error, late ready ignored
        id_valid = 1'b1; id_is_cop = 1'b1;
        id_operand = 32'hAAAA_5555; id_dest = 5'd9;
        req = 0; wbs = 0;
        for (int c = 0; c <= 60; c++) begin
            if (c == 1) begin
                id_valid = 1'b0; id_is_cop = 1'b0;
            end
            cop_ready = (c == 55);
            @(negedge clk);
            if (cop_req) req++;
            if (wb_en) wbs++;
            if (c == 49) check("timeout_err_set", 64'(timeout_err), 64'd1);
            next();
        end
        idle_inputs();
        check("timeout_req_len", 64'(req), 64'd48);
        check("timeout_no_wb", 64'(wbs), 64'd0);
        run_op(32'h0000_0003, 5'd4, 2, 32'h0000_0033);
        @(negedge clk);
        check("timeout_err_sticky", 64'(timeout_err), 64'd1);
        next();
`else
        // No timeout: BUSY waits well past TIMEOUT cycles
        run_op(32'h0000_00F0, 5'd20, 61, 32'h0BAD_CAFE);
        @(negedge clk);
        check("timeout_err_tied", 64'(timeout_err), 64'd0);
        next();
`endif

        // Reset in BUSY cycle 10, ready at cycle 20 ignored
        id_valid = 1'b1; id_is_cop = 1'b1;
        id_operand = 32'h0F0F_0F0F; id_dest = 5'd11;
        wbs = 0;
        for (int c = 0; c <= 24; c++) begin
            rst = (c == 10);
            if (c == 11) begin
                id_valid = 1'b0; id_is_cop = 1'b0; id_operand = '0;
            end
            cop_ready  = (c == 20);
            cop_result = 32'h1111_2222;
            @(negedge clk);
            if (wb_en) wbs++;
            if (c == 11) begin
                check("midrst_outs", {cop_req, cop_data, wb_en, wb_dest,
                                      wb_data, timeout_err}, 64'd0);
                check("midrst_freeze", 64'(freeze), 64'd0);
            end
            next();
        end
        idle_inputs();
        rst = 1'b0;
        check("midrst_no_wb", 64'(wbs), 64'd0);

        // Flushed cop op in IDLE
        id_valid = 1'b1; id_is_cop = 1'b1; flush = 1'b1;
        id_operand = 32'h5; id_dest = 5'd2;
        @(negedge clk);
        check("flush_freeze", 64'(freeze), 64'd0);
        next();
        idle_inputs();
        @(negedge clk);
        check("flush_no_req", 64'(cop_req), 64'd0);
        next();

        // Spurious ready in IDLE
        cop_ready = 1'b1; cop_result = 32'h7777_7777;
        next();
        cop_ready = 1'b0;
        @(negedge clk);
        check("spurious_no_wb", 64'(wb_en), 64'd0);
        next();

        // Back-to-back: second op issued during first op's WB
        sb.push_back({5'd5, 32'hAAAA_0001});
        sb.push_back({5'd3, 32'hBBBB_0002});
        lows = 0; first = -1; last = -1; req = 0;
        for (int c = 0; c <= 10; c++) begin
            id_valid   = (c <= 6);
            id_is_cop  = (c <= 6);
            id_operand = (c <= 3) ? 32'h1 : 32'h2;
            id_dest    = (c <= 3) ? 5'd5 : 5'd3;
            cop_ready  = (c == 3) || (c == 6);
            cop_result = (c == 3) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            @(negedge clk);
            if (cop_req) begin
                req++;
                if (first < 0) first = c;
                last = c;
            end
            if (c == 4) check("b2b_wb_freeze", 64'(freeze), 64'd1);
            if (c == 5) check("b2b_data2", 64'(cop_data), 64'h2);
            next();
        end
        idle_inputs();
        lows = (last - first + 1) - req;
        check("b2b_req_gap", 64'(lows), 64'd1);
        check("b2b_req_total", 64'(req), 64'd5);

        next();
        next();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
